// File: rtl/conv_encoder.sv
// conv_encoder
//   Rate-1/2, constraint-length-7 convolutional encoder (g0 = 133o, g1 = 171o)
//   for the 802.11a transmit chain. It takes scrambled WIDTH-bit AXI-Stream
//   beats and emits 2*WIDTH coded bits as two WIDTH-bit output beats.
//   Bit 0 of tdata is the earliest bit in time on both the input and the output.
//   Coded bit 2k is A_k and coded bit 2k+1 is B_k, where k is the input bit index.
//
// Parameters
//   WIDTH          beat width in bits; must be even and >= 8 (default 32)
//
// Optional feature (compile-time macro CONV_ENC_PKT_CNT_EN)
//   When defined, adds the output pkt_count[15:0]. It counts output handshakes
//   that carry m_axis_tlast and wraps from 0xFFFF to 0.
//
// Ports
//   aclk           in   clock
//   aresetn        in   asynchronous reset, active low
//   s_axis_tdata   in   scrambled data bits, bit 0 first
//   s_axis_tuser   in   4-bit sideband, copied onto both output beats
//   s_axis_tvalid  in   input valid
//   s_axis_tready  out  input ready
//   s_axis_tlast   in   last beat of packet; clears the encoder history
//   m_axis_tdata   out  coded bits, interleaved A,B per input bit
//   m_axis_tuser   out  copy of s_axis_tuser
//   m_axis_tvalid  out  output valid
//   m_axis_tready  in   output ready
//   m_axis_tlast   out  high only on the second output beat of a tlast input
//   pkt_count      out  packet counter (only with CONV_ENC_PKT_CNT_EN)
module conv_encoder #(
  parameter int WIDTH = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic [3:0]       s_axis_tuser,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic [3:0]       m_axis_tuser,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast
`ifdef CONV_ENC_PKT_CNT_EN
  ,
  output logic [15:0]      pkt_count
`endif
);

  typedef enum logic [1:0] {EMPTY, BEAT0, BEAT1} state_t;

  state_t             state;
  logic [5:0]         sr;        // sr[j-1] holds b_{n-j} for the next beat's bit 0
  logic [2*WIDTH-1:0] coded_p0;
  logic [2*WIDTH-1:0] hold_p1;
  logic               last_p1;
  logic               run;       // keeps tready low while reset is held
  logic               s_hs;
  logic               m_hs;

  // Encode one beat against the history. ext places the history below the
  // beat so that b_{n-j} for bit k is ext[k+6-j].
  function automatic logic [2*WIDTH-1:0] encode(input logic [WIDTH-1:0] d,
                                                input logic [5:0]       h);
    logic [WIDTH+5:0]   ext;
    logic [2*WIDTH-1:0] c;
    ext = {d, h[0], h[1], h[2], h[3], h[4], h[5]};
    c   = '0;
    for (int k = 0; k < WIDTH; k++) begin
      c[2*k]   = ext[k+6] ^ ext[k+4] ^ ext[k+3] ^ ext[k+1] ^ ext[k];
      c[2*k+1] = ext[k+6] ^ ext[k+5] ^ ext[k+4] ^ ext[k+3] ^ ext[k];
    end
    return c;
  endfunction

  // The newest input bit becomes b_{n-1}.
  function automatic logic [5:0] next_hist(input logic [WIDTH-1:0] d);
    logic [5:0] h;
    for (int i = 0; i < 6; i++) h[i] = d[WIDTH-1-i];
    return h;
  endfunction

  assign s_axis_tready = run & ((state == EMPTY) | ((state == BEAT1) & m_axis_tready));
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign m_hs          = m_axis_tvalid & m_axis_tready;

  // ---- stage p0: combinational encode of the accepted beat ----
  assign coded_p0 = encode(s_axis_tdata, sr);

  // ---- stage p1: hold register and output FSM ----
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= EMPTY;
      sr            <= '0;
      hold_p1       <= '0;
      last_p1       <= 1'b0;
      run           <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      run <= 1'b1;
      // An input can only be accepted in EMPTY, or in BEAT1 while the
      // second beat leaves, so loading takes priority over draining.
      if (s_hs) begin
        hold_p1       <= coded_p0;
        last_p1       <= s_axis_tlast;
        m_axis_tuser  <= s_axis_tuser;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= 1'b0;
        sr            <= s_axis_tlast ? 6'd0 : next_hist(s_axis_tdata);
        state         <= BEAT0;
      end else begin
        case (state)
          BEAT0: if (m_hs) begin
            m_axis_tlast <= last_p1;
            state        <= BEAT1;
          end
          BEAT1: if (m_hs) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            state         <= EMPTY;
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  // The output data is selected from registers only, so it stays stable under a stall.
  assign m_axis_tdata = (state == BEAT1) ? hold_p1[2*WIDTH-1:WIDTH] : hold_p1[WIDTH-1:0];

`ifdef CONV_ENC_PKT_CNT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                  pkt_count <= '0;
    else if (m_hs && m_axis_tlast) pkt_count <= pkt_count + 16'd1;
  end
`endif

endmodule
